// File: rtl/instr_prefetch_queue.sv
// ---------------------------------------------------------------------------
// instr_prefetch_queue
//
// Fetch stage that sits directly in front of the instruction-issue logic.
// It walks a fetch PC through a synchronous instruction memory. It buffers
// each returned word, together with the PC it came from, in a small circular
// queue. The queue head is handed to issue over a valid/ready handshake.
// A taken branch flushes the queue, throws away any memory response still in
// flight, and restarts fetch at the branch target.
//
// Ports
//   Clock               system clock, all state updates on the rising edge
//   Reset               synchronous, active-high; overrides everything else
//   iEnable             fetch enable; low only stops new memory reads
//   oInstrMemAddr       instruction memory read address (current fetch PC)
//   oInstrMemReadEnable memory read strobe
//   iInstrMemData       memory read data, valid one cycle after the strobe
//   oInstrValid         queue head holds a valid instruction
//   oInstr              queue head instruction word
//   oInstrPC            PC of the queue head instruction
//   iIssueReady         issue stage accepts the head this cycle
//   iBranchTaken        single-cycle redirect request
//   iBranchTarget       redirect PC
//   oQueueCount         number of occupied queue entries
// ---------------------------------------------------------------------------
module instr_prefetch_queue #(
   parameter int                ADDR_W   = 16,
   parameter int                INSTR_W  = 64,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     iEnable,
   output logic [ADDR_W-1:0]        oInstrMemAddr,
   output logic                     oInstrMemReadEnable,
   input  logic [INSTR_W-1:0]       iInstrMemData,
   output logic                     oInstrValid,
   output logic [INSTR_W-1:0]       oInstr,
   output logic [ADDR_W-1:0]        oInstrPC,
   input  logic                     iIssueReady,
   input  logic                     iBranchTaken,
   input  logic [ADDR_W-1:0]        iBranchTarget,
   output logic [$clog2(DEPTH):0]   oQueueCount
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0]  fetchPc;
   logic [ADDR_W-1:0]  inflightPc;
   logic               inflight;

   logic [PTR_W-1:0]   rdPtr;
   logic [PTR_W-1:0]   wrPtr;
   logic [CNT_W-1:0]   count;

   logic [INSTR_W-1:0] instrStore [DEPTH];
   logic [ADDR_W-1:0]  pcStore    [DEPTH];

   logic [CNT_W-1:0]   creditsUsed;
   logic               readStrobe;
   logic               pushEntry;
   logic               popEntry;

   // Handshake and credit decode. A new read is only allowed if its answer
   // is guaranteed a slot. Entries already queued plus the read still in
   // flight must leave room, so the queue can never be written while full.
   // A branch suppresses both the new read and the capture of the pending
   // response, because the pending word belongs to the abandoned path.
   always_comb begin
      creditsUsed = count + CNT_W'(inflight);
      readStrobe  = iEnable & ~iBranchTaken & ~Reset & (creditsUsed < CNT_W'(DEPTH));
      pushEntry   = inflight & ~iBranchTaken;
      popEntry    = (count != '0) & iIssueReady;
   end

   // Memory-side outputs. The read address is always the fetch PC. The
   // strobe tells the memory whether this cycle's address is a real request.
   always_comb begin
      oInstrMemAddr       = fetchPc;
      oInstrMemReadEnable = readStrobe;
   end

   // Fetch PC and in-flight tracking. Each strobe advances the PC by one and
   // wraps naturally at the top of the address space. The strobed PC is
   // remembered so it can be stored next to the data when the data returns.
   // The in-flight flag is high only in the cycle right after a strobe. A
   // branch drops that pending response and retargets fetch. A branch cannot
   // coincide with a strobe, so the two updates never conflict.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         fetchPc    <= RESET_PC;
         inflight   <= 1'b0;
         inflightPc <= '0;
      end else if (iBranchTaken) begin
         fetchPc    <= iBranchTarget;
         inflight   <= 1'b0;
      end else begin
         inflight <= readStrobe;
         if (readStrobe) begin
            fetchPc    <= fetchPc + ADDR_W'(1);
            inflightPc <= fetchPc;
         end
      end
   end

   // Queue bookkeeping. Both pointers wrap for free because DEPTH is a power
   // of two. A branch flushes by zeroing the count and the pointers. Any head
   // handshake in that same cycle has already been seen by issue and counts
   // as consumed. Nothing else is needed to honour it. A simultaneous push
   // and pop leaves the count unchanged.
   always_ff @(posedge Clock) begin
      if (Reset || iBranchTaken) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (pushEntry) begin
            wrPtr <= wrPtr + PTR_W'(1);
         end
         if (popEntry) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         count <= count + CNT_W'(pushEntry) - CNT_W'(popEntry);
      end
   end

   // Entry storage. Reset clears every slot so the head outputs read as zero
   // afterwards. A flush does not clear the storage. Stale slots are harmless
   // because the count gates validity and the head is rewritten before it is
   // shown again.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            instrStore[i] <= '0;
            pcStore[i]    <= '0;
         end
      end else if (pushEntry) begin
         instrStore[wrPtr] <= iInstrMemData;
         pcStore[wrPtr]    <= inflightPc;
      end
   end

   // Issue-side outputs. The head is read combinationally from registered
   // storage, so issue sees the instruction in the same cycle that valid
   // rises.
   always_comb begin
      oInstrValid = (count != '0);
      oInstr      = instrStore[rdPtr];
      oInstrPC    = pcStore[rdPtr];
      oQueueCount = count;
   end

   // The credit scheme should make a push into a full queue impossible.
   // There is no overflow handling, so this check flags it if it ever happens.
   noOverflow : assert property (@(posedge Clock) disable iff (Reset)
      !(pushEntry && (count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_prefetch_queue
//
// Self-checking bench for instr_prefetch_queue. It contains a synchronous
// instruction memory whose contents are a fixed function of the address.
//
// The reference model tracks the PC stream issue should see: a sequential
// run that starts at RESET_PC, or at the latest branch target. The model
// fills a scoreboard queue with the (pc, word) pairs expected next. An
// independent monitor pops one entry for every accepted head and compares
// it. Directed cycle checks cover latency, backpressure, branch timing,
// enable gating, address wrap and mid-run reset. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_instr_prefetch_queue;

   localparam int                ADDR_W   = 16;
   localparam int                INSTR_W  = 64;
   localparam int                DEPTH    = 4;
   localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

   logic                   Clock;
   logic                   Reset;
   logic                   iEnable;
   logic [ADDR_W-1:0]      oInstrMemAddr;
   logic                   oInstrMemReadEnable;
   logic [INSTR_W-1:0]     iInstrMemData;
   logic                   oInstrValid;
   logic [INSTR_W-1:0]     oInstr;
   logic [ADDR_W-1:0]      oInstrPC;
   logic                   iIssueReady;
   logic                   iBranchTaken;
   logic [ADDR_W-1:0]      iBranchTarget;
   logic [$clog2(DEPTH):0] oQueueCount;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] data;
   } expectEntryT;

   expectEntryT       expectQ[$];
   logic [ADDR_W-1:0] modelNextPc;
   int                nChecks = 0;
   int                nFails  = 0;
   int                acceptCnt = 0;

   instr_prefetch_queue #(
      .ADDR_W   (ADDR_W),
      .INSTR_W  (INSTR_W),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .Clock               (Clock),
      .Reset               (Reset),
      .iEnable             (iEnable),
      .oInstrMemAddr       (oInstrMemAddr),
      .oInstrMemReadEnable (oInstrMemReadEnable),
      .iInstrMemData       (iInstrMemData),
      .oInstrValid         (oInstrValid),
      .oInstr              (oInstr),
      .oInstrPC            (oInstrPC),
      .iIssueReady         (iIssueReady),
      .iBranchTaken        (iBranchTaken),
      .iBranchTarget       (iBranchTarget),
      .oQueueCount         (oQueueCount)
   );

   // Memory contents: the low word is 0x1000 + address. The top bits carry
   // a scrambled copy of the address, so a wrong word is easy to spot.
   function automatic logic [INSTR_W-1:0] memWord(input logic [ADDR_W-1:0] a);
      return {a ^ 16'h5A5A, 16'h0000, 32'h0000_1000 + 32'(a)};
   endfunction

   // Free-running clock with a 10-unit period.
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Synchronous instruction memory: the word for this cycle's address
   // appears on the data bus one cycle later.
   always @(posedge Clock) begin
      iInstrMemData <= memWord(oInstrMemAddr);
   end

   // Compare helper shared by the monitor and the directed checks.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge.
   task automatic applyStimulus(input logic rst, input logic en, input logic rdy,
                                input logic br, input logic [ADDR_W-1:0] tgt);
      @(posedge Clock);
      #1;
      Reset         = rst;
      iEnable       = en;
      iIssueReady   = rdy;
      iBranchTaken  = br;
      iBranchTarget = tgt;
   endtask

   // Reference model. It runs just after the monitor in each cycle, so any
   // handshake in a branch cycle consumes an old-path entry before the
   // redirect replaces the expected stream. The model keeps a window of
   // upcoming sequential PCs queued.
   always begin
      @(negedge Clock);
      #1;
      if (Reset) begin
         expectQ.delete();
         modelNextPc = RESET_PC;
      end else if (iBranchTaken) begin
         expectQ.delete();
         modelNextPc = iBranchTarget;
      end
      while (expectQ.size() < 2 * DEPTH) begin
         expectQ.push_back('{pc: modelNextPc, data: memWord(modelNextPc)});
         modelNextPc = modelNextPc + ADDR_W'(1);
      end
   end

   // Monitor: every accepted head must be the next scoreboard entry.
   always @(negedge Clock) begin : monitor
      expectEntryT e;
      if (!Reset && oInstrValid && iIssueReady) begin
         acceptCnt++;
         if (expectQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL scoreboardEmpty: got pc %h, expected no output", oInstrPC);
         end else begin
            e = expectQ.pop_front();
            checkOutput("headPC", 64'(oInstrPC), 64'(e.pc));
            checkOutput("headData", oInstr, e.data);
         end
      end
   end

   // Absolute time bound so the run always ends.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios followed by randomized traffic.
   initial begin
      int strobes;
      int base;
      Reset = 1'b1;
      iEnable = 1'b0;
      iIssueReady = 1'b0;
      iBranchTaken = 1'b0;
      iBranchTarget = '0;

      // Reset state
      repeat (3) applyStimulus(1, 0, 0, 0, 0);
      @(negedge Clock);
      checkOutput("rstValid", 64'(oInstrValid), 0);
      checkOutput("rstStrobe", 64'(oInstrMemReadEnable), 0);
      checkOutput("rstAddr", 64'(oInstrMemAddr), 64'(RESET_PC));
      checkOutput("rstInstr", oInstr, 0);
      checkOutput("rstPC", 64'(oInstrPC), 0);
      checkOutput("rstCount", 64'(oQueueCount), 0);

      // Straight-line fetch: strobe in cycle 0, valid from cycle 2
      applyStimulus(0, 1, 1, 0, 0);
      @(negedge Clock);
      checkOutput("firstStrobe", 64'(oInstrMemReadEnable), 1);
      checkOutput("firstAddr", 64'(oInstrMemAddr), 64'(RESET_PC));
      checkOutput("validCycle0", 64'(oInstrValid), 0);
      applyStimulus(0, 1, 1, 0, 0);
      @(negedge Clock);
      checkOutput("validCycle1", 64'(oInstrValid), 0);
      for (int c = 2; c <= 7; c++) begin
         applyStimulus(0, 1, 1, 0, 0);
         @(negedge Clock);
         checkOutput("streamValid", 64'(oInstrValid), 1);
         checkOutput("streamStrobe", 64'(oInstrMemReadEnable), 1);
      end
      checkOutput("addrCycle7", 64'(oInstrMemAddr), 64'(RESET_PC + 16'd7));

      // Branch while PC 7 is in flight
      applyStimulus(0, 1, 1, 1, 16'h0040);
      @(negedge Clock);
      checkOutput("brNoStrobe", 64'(oInstrMemReadEnable), 0);
      checkOutput("brHeadValid", 64'(oInstrValid), 1);
      applyStimulus(0, 1, 1, 0, 0);
      @(negedge Clock);
      checkOutput("brT1Strobe", 64'(oInstrMemReadEnable), 1);
      checkOutput("brT1Addr", 64'(oInstrMemAddr), 64'h0040);
      checkOutput("brT1Valid", 64'(oInstrValid), 0);
      applyStimulus(0, 1, 1, 0, 0);
      @(negedge Clock);
      checkOutput("brT2Valid", 64'(oInstrValid), 0);
      applyStimulus(0, 1, 1, 0, 0);
      @(negedge Clock);
      checkOutput("brT3Valid", 64'(oInstrValid), 1);
      checkOutput("brT3PC", 64'(oInstrPC), 64'h0040);
      repeat (3) applyStimulus(0, 1, 1, 0, 0);

      // Enable gating: no strobes, pending word delivered, queue drains
      for (int c = 0; c < 5; c++) begin
         applyStimulus(0, 0, 1, 0, 0);
         @(negedge Clock);
         checkOutput("gateNoStrobe", 64'(oInstrMemReadEnable), 0);
      end
      checkOutput("gateDrained", 64'(oQueueCount), 0);
      repeat (6) applyStimulus(0, 1, 1, 0, 0);

      // Backpressure from a fresh reset: four strobes, then a full queue
      repeat (2) applyStimulus(1, 1, 0, 0, 0);
      strobes = 0;
      for (int c = 0; c < 10; c++) begin
         applyStimulus(0, 1, 0, 0, 0);
         @(negedge Clock);
         if (oInstrMemReadEnable) strobes++;
      end
      checkOutput("bpStrobes", 64'(strobes), 4);
      checkOutput("bpCount", 64'(oQueueCount), 64'(DEPTH));
      checkOutput("bpStrobeLow", 64'(oInstrMemReadEnable), 0);
      repeat (12) applyStimulus(0, 1, 1, 0, 0);

      // Address wrap through the top of the PC space
      applyStimulus(0, 1, 1, 1, 16'hFFFE);
      base = acceptCnt;
      repeat (10) applyStimulus(0, 1, 1, 0, 0);
      checkOutput("wrapAccepts", 64'(acceptCnt - base >= 4), 1);

      // Reset mid-operation with a loaded queue and a read in flight
      repeat (2) applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 0);
      @(negedge Clock);
      checkOutput("midRstStrobe", 64'(oInstrMemReadEnable), 0);
      applyStimulus(0, 1, 1, 0, 0);
      @(negedge Clock);
      checkOutput("midRstValid", 64'(oInstrValid), 0);
      checkOutput("midRstCount", 64'(oQueueCount), 0);
      checkOutput("midRstInstr", oInstr, 0);
      checkOutput("midRstPC", 64'(oInstrPC), 0);
      checkOutput("midRstAddr", 64'(oInstrMemAddr), 64'(RESET_PC));
      checkOutput("midRstRestart", 64'(oInstrMemReadEnable), 1);
      applyStimulus(0, 1, 1, 0, 0);
      @(negedge Clock);
      checkOutput("staleIgnored", 64'(oInstrValid), 0);
      applyStimulus(0, 1, 1, 0, 0);
      @(negedge Clock);
      checkOutput("restartPC", 64'(oInstrPC), 64'(RESET_PC));

      // Randomized traffic: ready, enable, branches and the odd reset
      base = acceptCnt;
      for (int c = 0; c < 1500; c++) begin
         applyStimulus($urandom_range(0, 199) == 0,
                       $urandom_range(0, 7) != 0,
                       $urandom_range(0, 3) != 0,
                       $urandom_range(0, 15) == 0,
                       ADDR_W'($urandom));
      end
      checkOutput("randomProgress", 64'(acceptCnt - base > 200), 1);

      // Final drain with fetch disabled
      repeat (10) applyStimulus(0, 0, 1, 0, 0);
      @(negedge Clock);
      checkOutput("finalDrain", 64'(oQueueCount), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
